nodf_module_if: RTL and testbench
=================================

# nodf_module_if

Handshake status tracker for a non-dataflow HLS block (ap_ctrl_hs style). It watches the block's ap_start/ap_ready/ap_done/ap_continue signals and tracks the block's execution state. It counts transactions and measures per-transaction latency and start-to-start interval. The results feed the simulation sample manager / CSV status dumper, and a `finish` input freezes all statistics at end of test.

## Interface
Parameters:
- CNT_W, default 32: width of every counter and latency/interval field.

Ports:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ap_start  in  1  start request from the driver to the monitored block.
- ap_ready  in  1  monitored block has accepted its inputs.
- ap_done  in  1  monitored block has completed a transaction.
- ap_continue  in  1  downstream accepts the done; tie to 1 for plain ap_ctrl_hs.
- finish  in  1  end of simulation; freezes all outputs.
- state  out  2  0=IDLE, 1=ACTIVE, 2=STALL, 3=FINISHED.
- cycle_cnt  out  CNT_W  cycles since reset release.
- start_cnt  out  CNT_W  accepted starts.
- done_cnt  out  CNT_W  completed transactions.
- last_lat  out  CNT_W  latency of the most recent transaction.
- min_lat  out  CNT_W  minimum latency seen.
- max_lat  out  CNT_W  maximum latency seen.
- last_ii  out  CNT_W  most recent start-to-start interval.
- sample_valid  out  1  one-cycle pulse when a transaction completes.
- err_overlap  out  1  sticky flag; a second start was accepted while a transaction was outstanding.

## Operation
- A start is accepted (start event) in a cycle where ap_start=1 and ap_ready=1.
- A done is accepted (done event) in a cycle where ap_done=1 and ap_continue=1.
- FSM transitions:
  - IDLE→ACTIVE on the first cycle with ap_start=1. Record start_ts=cycle_cnt.
  - ACTIVE→STALL when ap_done=1 and ap_continue=0.
  - ACTIVE or STALL→IDLE on a done event.
  - A done event in the same cycle as ap_start=1 goes directly to ACTIVE with a new start_ts.
  - Any state→FINISHED when finish=1. FINISHED is absorbing until reset.
- On a done event:
  - last_lat = cycle_cnt − start_ts.
  - Update min_lat/max_lat.
  - done_cnt+1.
  - Pulse sample_valid.
- On a start event:
  - start_cnt+1.
  - From the second start on, last_ii = cycle_cnt − previous start cycle.
- A start event while start_cnt > done_cnt, and not in the same cycle as a done, sets err_overlap. start_ts is not overwritten in that case.
- Arithmetic is unsigned, modulo 2^CNT_W. Counters saturate at all-ones instead of wrapping.
- The first completed transaction initialises both min_lat and max_lat.
- done without a preceding start (IDLE): done_cnt increments, latency is not updated, and sample_valid still pulses.

## Timing
- All outputs are registered and update the cycle after the triggering edge. sample_valid is high for exactly one cycle.
- Reset values:
  - state=IDLE.
  - All counters and last_lat/max_lat/last_ii = 0.
  - min_lat = all-ones.
  - sample_valid=0, err_overlap=0.
- Reset asserted mid-transaction clears everything immediately (asynchronous). Reset release then starts cycle_cnt from 0.
- Once finish=1 is seen, no output changes again. finish and done in the same cycle: the done is not recorded.
- Zero-latency case: start and done in the same cycle from IDLE gives last_lat=0.

## Structure
- Shared package holds:
  - the state enum (IDLE/ACTIVE/STALL/FINISHED, 2 bits);
  - the CNT_W default;
  - a saturating-increment function.
- One natural sub-module, nodf_lat_stats: the min/max/last latency register bank, driven by the done strobe and latency value.

## Test plan
- Single transaction: ap_start high at cycle 5, ap_ready+ap_done at cycle 15, ap_continue=1 → last_lat=min_lat=max_lat=10, start_cnt=done_cnt=1, one sample_valid pulse, state returns to IDLE.
- Back-pressure: ap_done high at cycle 20 with ap_continue=0 for 3 cycles → state=STALL for 3 cycles; done counted once at cycle 23 with last_lat measured to cycle 23.
- Three back-to-back transactions with latencies 4, 9, 6 → min_lat=4, max_lat=9, last_lat=6; last_ii matches the start spacing.
- Overlap: second ap_start/ap_ready pulse before ap_done → err_overlap=1 and stays set; latency still measured from the first start.
- finish asserted during ACTIVE → state=FINISHED; a later ap_done leaves done_cnt and cycle_cnt unchanged.
- Reset pulse mid-ACTIVE → all outputs return to reset values immediately; min_lat=all-ones.

Source files
------------

// File: rtl/nodf_module_if_pkg.sv
// Shared types and helpers for the ap_ctrl_hs handshake status tracker.
package nodf_module_if_pkg;

  localparam int CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_STALL    = 2'd2,
    ST_FINISHED = 2'd3
  } state_e;

  // Increment that sticks at max_v; callers zero-extend to 64 bits and truncate back.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
    return (v >= max_v) ? max_v : v + 64'd1;
  endfunction

endpackage

// File: rtl/nodf_lat_stats.sv
// Last/min/max latency register bank, updated on each completed transaction with a valid latency.
module nodf_lat_stats #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             upd,
  input  logic [CNT_W-1:0] lat,
  output logic [CNT_W-1:0] last_lat,
  output logic [CNT_W-1:0] min_lat,
  output logic [CNT_W-1:0] max_lat
);

  logic [CNT_W-1:0] last_lat_q, last_lat_d;
  logic [CNT_W-1:0] min_lat_q, min_lat_d;
  logic [CNT_W-1:0] max_lat_q, max_lat_d;

  // min starts at all-ones and max at zero, so the first sample initialises both.
  always_comb begin
    last_lat_d = last_lat_q;
    min_lat_d  = min_lat_q;
    max_lat_d  = max_lat_q;
    if (upd) begin
      last_lat_d = lat;
      if (lat < min_lat_q) min_lat_d = lat;
      if (lat > max_lat_q) max_lat_d = lat;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_lat_q <= '0;
      min_lat_q  <= '1;
      max_lat_q  <= '0;
    end else begin
      last_lat_q <= last_lat_d;
      min_lat_q  <= min_lat_d;
      max_lat_q  <= max_lat_d;
    end
  end

  assign last_lat = last_lat_q;
  assign min_lat  = min_lat_q;
  assign max_lat  = max_lat_q;

endmodule

// File: rtl/nodf_module_if.sv
// Handshake status tracker for an ap_ctrl_hs block: execution state, transaction counts,
// latency and start-to-start interval, frozen once finish is seen.
module nodf_module_if
  import nodf_module_if_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] start_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [CNT_W-1:0] last_lat,
  output logic [CNT_W-1:0] min_lat,
  output logic [CNT_W-1:0] max_lat,
  output logic [CNT_W-1:0] last_ii,
  output logic             sample_valid,
  output logic             err_overlap
);

  localparam logic [63:0] CNT_MAX = 64'({CNT_W{1'b1}});

  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] v);
    return CNT_W'(sat_inc(64'(v), CNT_MAX));
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] start_cnt_q, start_cnt_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
  logic [CNT_W-1:0] start_ts_q, start_ts_d;
  logic [CNT_W-1:0] prev_start_q, prev_start_d;
  logic [CNT_W-1:0] last_ii_q, last_ii_d;
  logic             acc_q, acc_d;
  logic             sample_valid_q, sample_valid_d;
  logic             err_overlap_q, err_overlap_d;
  logic             lat_upd;
  logic [CNT_W-1:0] lat_val;
  logic             start_ev;
  logic             done_ev;

  assign start_ev = ap_start & ap_ready;
  assign done_ev  = ap_done & ap_continue;

  // acc_q: the outstanding transaction's start has been accepted, so an ap_start seen
  // alongside its done is a fresh request rather than the same held start.
  always_comb begin
    state_d        = state_q;
    cycle_cnt_d    = cycle_cnt_q;
    start_cnt_d    = start_cnt_q;
    done_cnt_d     = done_cnt_q;
    start_ts_d     = start_ts_q;
    prev_start_d   = prev_start_q;
    last_ii_d      = last_ii_q;
    acc_d          = acc_q;
    err_overlap_d  = err_overlap_q;
    sample_valid_d = 1'b0;
    lat_upd        = 1'b0;
    lat_val        = '0;
    if (state_q != ST_FINISHED) begin
      if (finish) begin
        state_d = ST_FINISHED;
      end else begin
        cycle_cnt_d = inc(cycle_cnt_q);
        if (start_ev) begin
          start_cnt_d  = inc(start_cnt_q);
          prev_start_d = cycle_cnt_q;
          if (start_cnt_q != '0) last_ii_d = cycle_cnt_q - prev_start_q;
          if ((start_cnt_q > done_cnt_q) && !done_ev) err_overlap_d = 1'b1;
        end
        if (done_ev) begin
          done_cnt_d     = inc(done_cnt_q);
          sample_valid_d = 1'b1;
        end
        case (state_q)
          ST_IDLE: begin
            if (ap_start) begin
              if (done_ev) begin
                lat_upd = 1'b1;
                acc_d   = 1'b0;
              end else begin
                state_d    = ST_ACTIVE;
                start_ts_d = cycle_cnt_q;
                acc_d      = start_ev;
              end
            end
          end
          default: begin
            if (done_ev) begin
              lat_upd = 1'b1;
              lat_val = cycle_cnt_q - start_ts_q;
              if (ap_start && acc_q) begin
                state_d    = ST_ACTIVE;
                start_ts_d = cycle_cnt_q;
                acc_d      = start_ev;
              end else begin
                state_d = ST_IDLE;
                acc_d   = 1'b0;
              end
            end else begin
              if (ap_done) state_d = ST_STALL;
              acc_d = acc_q | start_ev;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      cycle_cnt_q    <= '0;
      start_cnt_q    <= '0;
      done_cnt_q     <= '0;
      start_ts_q     <= '0;
      prev_start_q   <= '0;
      last_ii_q      <= '0;
      acc_q          <= 1'b0;
      sample_valid_q <= 1'b0;
      err_overlap_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cycle_cnt_q    <= cycle_cnt_d;
      start_cnt_q    <= start_cnt_d;
      done_cnt_q     <= done_cnt_d;
      start_ts_q     <= start_ts_d;
      prev_start_q   <= prev_start_d;
      last_ii_q      <= last_ii_d;
      acc_q          <= acc_d;
      sample_valid_q <= sample_valid_d;
      err_overlap_q  <= err_overlap_d;
    end
  end

  nodf_lat_stats #(.CNT_W(CNT_W)) u_stats (
    .clock    (clock),
    .reset    (reset),
    .upd      (lat_upd),
    .lat      (lat_val),
    .last_lat (last_lat),
    .min_lat  (min_lat),
    .max_lat  (max_lat)
  );

  assign state        = state_q;
  assign cycle_cnt    = cycle_cnt_q;
  assign start_cnt    = start_cnt_q;
  assign done_cnt     = done_cnt_q;
  assign last_ii      = last_ii_q;
  assign sample_valid = sample_valid_q;
  assign err_overlap  = err_overlap_q;

endmodule

// File: tb/tb_nodf_module_if.sv
// Scoreboard bench for nodf_module_if: expected done records are queued as stimulus is
// driven and compared whenever the tracker pulses sample_valid.
module tb_nodf_module_if;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         ap_start, ap_ready, ap_done, ap_continue, finish;
  logic [1:0]   state;
  logic [W-1:0] cycle_cnt, start_cnt, done_cnt, last_lat, min_lat, max_lat, last_ii;
  logic         sample_valid, err_overlap;

  nodf_module_if #(.CNT_W(W)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .state(state),
    .cycle_cnt(cycle_cnt), .start_cnt(start_cnt), .done_cnt(done_cnt),
    .last_lat(last_lat), .min_lat(min_lat), .max_lat(max_lat), .last_ii(last_ii),
    .sample_valid(sample_valid), .err_overlap(err_overlap)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit     chk_lat;
    longint lat;
    longint dcnt;
  } sb_t;

  sb_t    sb_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  int     cyc;
  longint exp_done = 0;
  logic   prev_sv = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clock or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_done(input bit chk_lat, input longint lat);
    sb_t e;
    exp_done++;
    e.chk_lat = chk_lat;
    e.lat     = lat;
    e.dcnt    = exp_done;
    sb_q.push_back(e);
  endtask

  task automatic chk_reset();
    chk("rst_state", 64'(state), 0);
    chk("rst_cycle", 64'(cycle_cnt), 0);
    chk("rst_start", 64'(start_cnt), 0);
    chk("rst_done", 64'(done_cnt), 0);
    chk("rst_last", 64'(last_lat), 0);
    chk("rst_min", 64'(min_lat), 64'h0000_0000_FFFF_FFFF);
    chk("rst_max", 64'(max_lat), 0);
    chk("rst_ii", 64'(last_ii), 0);
    chk("rst_sv", 64'(sample_valid), 0);
    chk("rst_err", 64'(err_overlap), 0);
  endtask

  always @(negedge clock) begin
    sb_t e;
    if (reset) begin
      if (sample_valid && prev_sv) chk("sv_width", 2, 1);
      if (sample_valid) begin
        if (sb_q.size() == 0) begin
          chk("sv_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_done_cnt", 64'(done_cnt), 64'(e.dcnt));
          if (e.chk_lat) chk("sb_last_lat", 64'(last_lat), 64'(e.lat));
        end
      end
    end
    prev_sv <= sample_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0;
    repeat (2) @(posedge clock);
    #1 chk_reset();
    @(negedge clock) reset = 1'b1;

    // Single transaction: start held from 5, ready+done at 15.
    at_cycle(3);  chk("cycle_cnt", 64'(cycle_cnt), 3);
    at_cycle(5);  ap_start = 1;
    at_cycle(6);  chk("t1_active", 64'(state), 1);
    at_cycle(15); ap_ready = 1; ap_done = 1; push_done(1, 10);
    at_cycle(16); ap_start = 0; ap_ready = 0; ap_done = 0;
    chk("t1_state", 64'(state), 0);
    chk("t1_start", 64'(start_cnt), 1);
    chk("t1_min", 64'(min_lat), 10);
    chk("t1_max", 64'(max_lat), 10);
    chk("t1_sv", 64'(sample_valid), 1);
    at_cycle(17); chk("t1_sv_off", 64'(sample_valid), 0);

    // Back-pressure: done held with ap_continue low for 3 cycles.
    at_cycle(18); ap_start = 1; ap_ready = 1;
    at_cycle(19); ap_start = 0; ap_ready = 0; chk("t2_ii", 64'(last_ii), 3);
    at_cycle(20); ap_done = 1; ap_continue = 0;
    at_cycle(21); chk("t2_stall1", 64'(state), 2);
    at_cycle(22); chk("t2_stall2", 64'(state), 2);
    at_cycle(23); chk("t2_stall3", 64'(state), 2); chk("t2_done_hold", 64'(done_cnt), 1);
    ap_continue = 1; push_done(1, 5);
    at_cycle(24); ap_done = 0;
    chk("t2_state", 64'(state), 0);
    chk("t2_min", 64'(min_lat), 5);
    chk("t2_max", 64'(max_lat), 10);

    // Reset pulse mid-ACTIVE.
    at_cycle(26); ap_start = 1;
    at_cycle(28); chk("rb_active", 64'(state), 1);
    #2 reset = 1'b0;
    #1 chk_reset();
    ap_start = 0; sb_q.delete(); exp_done = 0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;

    // Three transactions with latencies 4, 9, 6.
    at_cycle(5);  ap_start = 1; ap_ready = 1;
    at_cycle(6);  ap_start = 0; ap_ready = 0;
    chk("t3_ii_first", 64'(last_ii), 0); chk("t3_start1", 64'(start_cnt), 1);
    at_cycle(9);  ap_done = 1; push_done(1, 4);
    at_cycle(10); ap_done = 0;
    at_cycle(15); ap_start = 1; ap_ready = 1;
    at_cycle(16); ap_start = 0; ap_ready = 0; chk("t3_ii2", 64'(last_ii), 10);
    at_cycle(24); ap_done = 1; push_done(1, 9);
    at_cycle(25); ap_done = 0;
    at_cycle(30); ap_start = 1; ap_ready = 1;
    at_cycle(31); ap_start = 0; ap_ready = 0; chk("t3_ii3", 64'(last_ii), 15);
    at_cycle(36); ap_done = 1; push_done(1, 6);
    at_cycle(37); ap_done = 0;
    chk("t3_min", 64'(min_lat), 4);
    chk("t3_max", 64'(max_lat), 9);
    chk("t3_last", 64'(last_lat), 6);
    chk("t3_start", 64'(start_cnt), 3);
    chk("t3_err", 64'(err_overlap), 0);

    // Overlap: second accepted start before the first completes.
    at_cycle(40); ap_start = 1; ap_ready = 1;
    at_cycle(41); ap_start = 0; ap_ready = 0; chk("ov_err_pre", 64'(err_overlap), 0);
    at_cycle(44); ap_start = 1; ap_ready = 1;
    at_cycle(45); ap_start = 0; ap_ready = 0; chk("ov_err", 64'(err_overlap), 1);
    at_cycle(50); ap_done = 1; push_done(1, 10);
    at_cycle(51); ap_done = 0;
    chk("ov_err_sticky", 64'(err_overlap), 1);
    chk("ov_max", 64'(max_lat), 10);
    chk("ov_state", 64'(state), 0);

    // Done with no preceding start: counted, latency untouched.
    at_cycle(53); ap_done = 1; push_done(0, 0);
    at_cycle(54); ap_done = 0;
    chk("orph_last", 64'(last_lat), 10);
    chk("orph_state", 64'(state), 0);

    // Zero latency: start and done together from IDLE.
    at_cycle(55); ap_start = 1; ap_ready = 1; ap_done = 1; push_done(1, 0);
    at_cycle(56); ap_start = 0; ap_ready = 0; ap_done = 0;
    chk("zl_min", 64'(min_lat), 0);
    chk("zl_state", 64'(state), 0);
    chk("zl_start", 64'(start_cnt), 6);
    chk("zl_ii", 64'(last_ii), 11);

    // finish during ACTIVE freezes everything; a later done is ignored.
    at_cycle(60); ap_start = 1; ap_ready = 1;
    at_cycle(61); ap_start = 0; ap_ready = 0; chk("fin_active", 64'(state), 1);
    at_cycle(63); finish = 1;
    at_cycle(64); chk("fin_state", 64'(state), 3); chk("fin_cycle", 64'(cycle_cnt), 63);
    at_cycle(66); ap_done = 1;
    at_cycle(67); ap_done = 0;
    at_cycle(68);
    chk("fin_done", 64'(done_cnt), 6);
    chk("fin_cycle_hold", 64'(cycle_cnt), 63);
    chk("fin_state_hold", 64'(state), 3);
    chk("fin_start", 64'(start_cnt), 7);
    chk("fin_ii", 64'(last_ii), 5);
    chk("fin_sv", 64'(sample_valid), 0);
    at_cycle(70);
    chk("sb_drain", 64'(sb_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
